load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-stage load/store unit between the pipeline's EX/MEM register and the word-addressed data memory (sync write, 1-cycle registered read). Converts byte-addressed byte/half/word requests into word accesses. Performs sign/zero extension on loads and read-modify-write for sub-word stores. Stalls the pipeline via a ready/valid handshake.

Parameters:
WORD_WIDTH, 32, data word width; the byte-lane logic is fixed at 4 lanes.
ADDR_WIDTH, 10, data-memory word-index width (1024 words).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  WORD_WIDTH  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid: misaligned, out-of-range or reserved size
resp_rdata  out  WORD_WIDTH  extended load data; held until the next response
mem_write  out  1  to data memory
mem_read  out  1  to data memory
mem_addr  out  ADDR_WIDTH  word index = addr[ADDR_WIDTH+1:2]
mem_wdata  out  WORD_WIDTH  to data memory
mem_rdata  in  WORD_WIDTH  from data memory, valid the cycle after mem_read

Behaviour:
- Reset (rst low, asynchronous): state = IDLE. req_ready = 1. All other outputs = 0: resp_valid, resp_err, resp_rdata, mem_write, mem_read, mem_addr, mem_wdata. Latched request registers are cleared.
- Reset mid-operation aborts the operation: no further memory access is issued and no response is produced.
- Handshake: the request is accepted on a rising edge when req_valid && req_ready. addr, size, unsigned, write and wdata are latched at that edge. Inputs are ignored while req_ready = 0.
- Error check at accept. An error is any of:
  - size = 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:ADDR_WIDTH+2] != 0.
- On error: go to RESP with resp_err = 1. No memory access is made and resp_rdata is unchanged.
- States: IDLE, ISSUE, WAIT, WRITE, RESP. Cycle T is the accept edge.
- Word store: ISSUE (T+1) drives mem_write = 1 with req_wdata, then RESP (T+2).
- Load: ISSUE (T+1) drives mem_read = 1. WAIT (T+2) extracts mem_rdata and registers it into resp_rdata. RESP (T+3).
- Byte/half store (read-modify-write):
  - ISSUE (T+1) drives mem_read = 1.
  - WAIT (T+2) merges the store lanes into mem_rdata and registers the result.
  - WRITE (T+3) drives mem_write = 1 with the merged word.
  - RESP (T+4).
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. req_ready rises on the following cycle; back-to-back throughput is one request per (latency + 1) cycles.
- mem_write and mem_read are never high in the same cycle. mem_addr holds the latched word index from ISSUE through WRITE and holds its value elsewhere.
- Lanes are little-endian:
  - byte k is bits [8k+7:8k] with k = addr[1:0];
  - a half occupies lanes addr[1]*2 and addr[1]*2+1.
- Load extension: 8/16-bit values are extended to 32 bits (sign or zero per req_unsigned); words pass through unchanged.
- Store merge: only the selected lanes are replaced with the low bits of req_wdata. The other lanes keep the mem_rdata value.

Decomposition:
- Shared defines file gains `SIZE_BYTE 2'b00, `SIZE_HALF 2'b01, `SIZE_WORD 2'b10, plus the state encodings (3-bit). WORD_WIDTH comes from the existing defines.
- One natural sub-module: lsu_lane_align. It is purely combinational: (rdata, addr[1:0], size, unsigned, wdata) -> (extended load data, merged store word). It is instantiated once and used in WAIT.

Test Plan:
- Reset: hold rst low mid-RMW (in WAIT), release -> mem_write never asserted, no resp_valid, req_ready = 1, resp_rdata = 0.
- Word store then load: store 0xDEADBEEF @0x10 -> mem_write in T+1, mem_addr = 4, resp_valid at T+2. Load word @0x10 -> resp_rdata = 0xDEADBEEF, resp_valid at T+3.
- Byte/half loads with extension, memory word 0x80FF7F01 @0x20:
  - lb @0x22 -> 0xFFFFFFFF; lbu @0x22 -> 0x000000FF;
  - lh @0x22 -> 0xFFFF80FF; lhu @0x20 -> 0x00007F01.
- RMW store: word 0x11223344 @0x30, sb 0xAB @0x31 -> mem_read T+1, mem_write T+3 with 0x1122AB44, resp T+4. Then sh 0xCDEF @0x32 -> 0xCDEFAB44.
- Errors: lw @0x02, sh @0x05, size 11, addr 0x00001000 -> each gives resp_valid & resp_err at T+1, no mem_read/mem_write, resp_rdata unchanged.
- Handshake: hold req_valid high with changing inputs while busy -> only the latched request executes; req_ready is low from T+1 until the cycle after RESP.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// load_store_unit_pkg : access sizes, FSM states and request error helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

  localparam int WORD_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int NUM_LANES      = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  // Reserved size is folded in here so callers only add the range check.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = |addr_lo;
      SIZE_RSVD: bad = 1'b1;
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ============================================================================
// load_store_unit_if : pipeline request/response and data-memory bus bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [WORD_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_err;
  logic [WORD_WIDTH-1:0] resp_rdata;

  logic                  mem_write;
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;

  // Master is the pipeline plus data memory; slave is the load/store unit.
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_err, resp_rdata,
    input  mem_write, mem_read, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_err, resp_rdata,
    output mem_write, mem_read, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/load_store_unit_lane_align.sv
// ============================================================================
// lsu_lane_align : little-endian lane extract/extend and sub-word store merge
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_lane_align
  import load_store_unit_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic [WORD_WIDTH-1:0] rdata_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic [WORD_WIDTH-1:0] load_data_o,
  output logic [WORD_WIDTH-1:0] store_word_o
);

  localparam int LANE_W = WORD_WIDTH / NUM_LANES;

  logic [LANE_W-1:0]   byte_sel;
  logic [2*LANE_W-1:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[1*LANE_W +: LANE_W];
      2'd2:    byte_sel = rdata_i[2*LANE_W +: LANE_W];
      2'd3:    byte_sel = rdata_i[3*LANE_W +: LANE_W];
      default: byte_sel = rdata_i[0 +: LANE_W];
    endcase

    half_sel = addr_lo_i[1] ? rdata_i[2*LANE_W +: 2*LANE_W]
                            : rdata_i[0 +: 2*LANE_W];

    case (size_i)
      SIZE_BYTE: load_data_o = {{(WORD_WIDTH-LANE_W){~unsigned_i & byte_sel[LANE_W-1]}},
                                byte_sel};
      SIZE_HALF: load_data_o = {{(WORD_WIDTH-2*LANE_W){~unsigned_i & half_sel[2*LANE_W-1]}},
                                half_sel};
      default:   load_data_o = rdata_i;
    endcase
  end

  // Each lane either takes its store byte or keeps the word read from memory.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic              lane_en;
    logic [LANE_W-1:0] lane_src;

    always_comb begin
      case (size_i)
        SIZE_BYTE: begin
          lane_en  = (addr_lo_i == 2'(k));
          lane_src = wdata_i[0 +: LANE_W];
        end
        SIZE_HALF: begin
          lane_en  = (addr_lo_i[1] == 1'(k / 2));
          lane_src = wdata_i[(k % 2)*LANE_W +: LANE_W];
        end
        default: begin
          lane_en  = 1'b1;
          lane_src = wdata_i[k*LANE_W +: LANE_W];
        end
      endcase
    end

    assign store_word_o[k*LANE_W +: LANE_W] = lane_en ? lane_src
                                                      : rdata_i[k*LANE_W +: LANE_W];
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : byte/half/word loads and stores onto a word-wide memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  load_store_unit_if.slave  bus_if
);

  lsu_state_e state_q, state_d;

  logic [1:0]            size_q;
  logic [1:0]            addr_lo_q;
  logic                  unsigned_q;
  logic                  write_q;
  logic                  err_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WORD_WIDTH-1:0] mem_wdata_q;
  logic [WORD_WIDTH-1:0] resp_rdata_q;

  logic                  accept;
  logic                  req_err;
  logic                  word_store;
  logic [WORD_WIDTH-1:0] load_data;
  logic [WORD_WIDTH-1:0] store_word;

  assign accept  = (state_q == ST_IDLE) && bus_if.req_valid;
  assign req_err = is_misaligned(bus_if.req_size, bus_if.req_addr[1:0])
                 | (|bus_if.req_addr[31:ADDR_WIDTH+2]);

  // Full-word stores skip the read half of read-modify-write.
  assign word_store = write_q && (size_q == SIZE_WORD);

  lsu_lane_align #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_lane_align (
    .rdata_i      (bus_if.mem_rdata),
    .addr_lo_i    (addr_lo_q),
    .size_i       (size_q),
    .unsigned_i   (unsigned_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    bus_if.req_ready  = 1'b0;
    bus_if.mem_read   = 1'b0;
    bus_if.mem_write  = 1'b0;
    bus_if.resp_valid = 1'b0;
    bus_if.resp_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus_if.req_ready = 1'b1;
        if (bus_if.req_valid) begin
          state_d = req_err ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (word_store) begin
          bus_if.mem_write = 1'b1;
          state_d          = ST_RESP;
        end else begin
          bus_if.mem_read = 1'b1;
          state_d         = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_d = write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        bus_if.mem_write = 1'b1;
        state_d          = ST_RESP;
      end
      ST_RESP: begin
        bus_if.resp_valid = 1'b1;
        bus_if.resp_err   = err_q;
        state_d           = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      size_q       <= '0;
      addr_lo_q    <= '0;
      unsigned_q   <= 1'b0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
    end else begin
      if (accept) begin
        size_q     <= bus_if.req_size;
        addr_lo_q  <= bus_if.req_addr[1:0];
        unsigned_q <= bus_if.req_unsigned;
        write_q    <= bus_if.req_write;
        err_q      <= req_err;
        wdata_q    <= bus_if.req_wdata;
        // Rejected requests leave the memory-facing registers untouched.
        if (!req_err) begin
          mem_addr_q <= bus_if.req_addr[ADDR_WIDTH+1:2];
          if (bus_if.req_write && (bus_if.req_size == SIZE_WORD)) begin
            mem_wdata_q <= bus_if.req_wdata;
          end
        end
      end

      if (state_q == ST_WAIT) begin
        if (write_q) begin
          mem_wdata_q <= store_word;
        end else begin
          resp_rdata_q <= load_data;
        end
      end
    end
  end

  assign bus_if.mem_addr   = mem_addr_q;
  assign bus_if.mem_wdata  = mem_wdata_q;
  assign bus_if.resp_rdata = resp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// tb_load_store_unit : directed requests checked against a transaction model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  localparam int K_ERR = 0;
  localparam int K_WST = 1;
  localparam int K_LD  = 2;
  localparam int K_RMW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  load_store_unit_if #(.WORD_WIDTH(32), .ADDR_WIDTH(10)) bus ();

  load_store_unit #(
    .WORD_WIDTH (32),
    .ADDR_WIDTH (10)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, one-cycle registered read.
  bit [31:0] env_mem [0:1023];
  always @(posedge clk) begin
    if (bus.mem_write) env_mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_read)  bus.mem_rdata <= env_mem[bus.mem_addr];
  end

  // Transaction-level model state.
  bit [31:0]   ref_mem [0:1023];
  int          checks = 0;
  int          errors = 0;
  bit          busy = 1'b0;
  bit          suspend = 1'b0;
  int          k = 0;
  int          lat = 0;
  int          kind = 0;
  bit          exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] new_rdata = '0;
  logic [31:0] exp_wdata = '0;
  logic [9:0]  exp_idx = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  // k counts cycles since the accept edge; lat is the cycle resp_valid is due.
  always @(negedge clk) begin
    bit e_rd, e_wr, e_rv;
    if (rst_n && !suspend) begin
      e_rd = 1'b0;
      e_wr = 1'b0;
      e_rv = 1'b0;
      if (busy) begin
        k++;
        e_rd = (k == 1) && (kind == K_LD || kind == K_RMW);
        e_wr = (k == 1 && kind == K_WST) || (k == 3 && kind == K_RMW);
        e_rv = (k == lat);
        if (e_rv && kind == K_LD) exp_rdata = new_rdata;
      end
      chk("req_ready",  32'(bus.req_ready),  32'(!busy));
      chk("mem_read",   32'(bus.mem_read),   32'(e_rd));
      chk("mem_write",  32'(bus.mem_write),  32'(e_wr));
      chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
      chk("resp_err",   32'(bus.resp_err),   32'(e_rv && exp_err));
      chk("resp_rdata", bus.resp_rdata, exp_rdata);
      if (e_rd || e_wr) chk("mem_addr", 32'(bus.mem_addr), 32'(exp_idx));
      if (e_wr)         chk("mem_wdata", bus.mem_wdata, exp_wdata);
      if (busy && k >= lat) busy = 1'b0;
    end
  end

  // Drives one request from an idle cycle; hold keeps req_valid high with junk while busy.
  task automatic issue(input bit wr, input bit [1:0] sz, input bit uns,
                       input bit [31:0] a, input bit [31:0] wd, input bit hold);
    bit [31:0] w, nw, rv, msk;
    bit [9:0]  idx;
    bit        e;
    int        sh, n;
    e   = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
          (sz == 2'b10 && a[1:0] != 2'b00) || (a[31:12] != 20'd0);
    idx = a[11:2];
    w   = ref_mem[idx];
    sh  = (sz == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    msk = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    rv  = (w >> sh) & msk;
    if (sz == 2'b10) rv = w;
    else if (!uns && (rv & ((msk >> 1) + 32'd1)) != 0) rv = rv | ~msk;
    nw  = (sz == 2'b10) ? wd : ((w & ~(msk << sh)) | ((wd & msk) << sh));

    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    if (e) begin
      kind = K_ERR; lat = 1;
    end else if (!wr) begin
      kind = K_LD; lat = 3; new_rdata = rv;
    end else begin
      kind = (sz == 2'b10) ? K_WST : K_RMW;
      lat  = (sz == 2'b10) ? 2 : 4;
      ref_mem[idx] = nw;
      exp_wdata    = nw;
    end
    exp_err = e;
    exp_idx = idx;
    k       = 0;
    busy    = 1'b1;
    #1;
    if (!hold) bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      if (busy && hold) begin
        #1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h14 + 32'(4 * n);
        bus.req_wdata = 32'hBAD0_0000 | 32'(n);
      end
    end while (busy && n < 20);
    #1 bus.req_valid = 1'b0;
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL timeout: request at 0x%08h, response not seen within 20 cycles", a);
      busy = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst_mem_write",  32'(bus.mem_write),  32'd0);
    chk("rst_mem_read",   32'(bus.mem_read),   32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_mem_wdata",  bus.mem_wdata,       32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Word store then load.
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    chk("sw_mem4", env_mem[4], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("lw_0x10", bus.resp_rdata, 32'hDEADBEEF);

    // Sub-word loads with extension from 0x80FF7F01.
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 1'b0);
    chk("lb_0x22", bus.resp_rdata, 32'hFFFFFFFF);
    issue(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 1'b0);
    chk("lbu_0x22", bus.resp_rdata, 32'h000000FF);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b0);
    chk("lh_0x22", bus.resp_rdata, 32'hFFFF80FF);
    issue(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 1'b0);
    chk("lhu_0x20", bus.resp_rdata, 32'h00007F01);
    issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("lb_0x20", bus.resp_rdata, 32'h00000001);
    issue(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("lh_0x20", bus.resp_rdata, 32'h00007F01);

    // Read-modify-write stores.
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h000000AB, 1'b0);
    chk("sb_0x31", env_mem[12], 32'h1122AB44);
    issue(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000CDEF, 1'b0);
    chk("sh_0x32", env_mem[12], 32'hCDEFAB44);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b0);
    chk("lw_0x30", bus.resp_rdata, 32'hCDEFAB44);

    // Error requests.
    issue(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h05, 32'h1234, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b0);
    chk("err_rdata_held", bus.resp_rdata, 32'hCDEFAB44);
    chk("err_no_store",   env_mem[1],     32'h0);

    // Busy-time inputs are ignored.
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    chk("hold_lw", bus.resp_rdata, 32'hDEADBEEF);
    chk("hold_mem5", env_mem[5], 32'h0);
    chk("hold_mem6", env_mem[6], 32'h0);

    // Reset in the middle of a read-modify-write.
    suspend          = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h21;
    bus.req_wdata    = 32'h55;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mrst_mem_write",  32'(bus.mem_write),  32'd0);
      chk("mrst_mem_read",   32'(bus.mem_read),   32'd0);
      chk("mrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("mrst_req_ready",  32'(bus.req_ready),  32'd1);
      chk("mrst_resp_rdata", bus.resp_rdata,      32'd0);
    end
    #1 rst_n = 1'b1;
    exp_rdata = '0;
    suspend   = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("mrst_mem8", env_mem[8], 32'h80FF7F01);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("mrst_lw_0x20", bus.resp_rdata, 32'h80FF7F01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
